// File: rtl/image_load_controller.sv
// image_load_controller
// Loads one RGB332 frame from the SD card into the framebuffer. The block
// issues consecutive SD block reads and counts the formatted pixel stream at
// one byte per pixel. Each accepted pixel becomes a framebuffer write at a
// linear address. The block reports completion, or a protocol error when a
// block is short. All outputs are registered.

module image_load_controller #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int ADDR_W      = 15,
  parameter int BLOCK_BYTES = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       start_block,
  output logic              sd_rd_req,
  output logic [31:0]       sd_rd_block,
  input  logic              sd_rd_ack,
  input  logic              sd_rd_done,
  input  logic [7:0]        pixel_data,
  input  logic              pixel_valid,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  localparam int FRAME_PIX = H_RES * V_RES;
  // One extra bit so the pixel counter can reach FRAME_PIX even when the
  // frame exactly fills the address space.
  localparam int PIX_W = ADDR_W + 1;
  localparam int BC_W  = $clog2(BLOCK_BYTES + 1);

  localparam logic [PIX_W-1:0] FRAME_PIX_C   = PIX_W'(FRAME_PIX);
  localparam logic [BC_W-1:0]  BLOCK_BYTES_C = BC_W'(BLOCK_BYTES);
  localparam logic [PIX_W-1:0] PIX_ONE_C     = PIX_W'(1);
  localparam logic [BC_W-1:0]  BC_ONE_C      = BC_W'(1);
  localparam logic [BC_W-1:0]  BC_ZERO_C     = BC_W'(0);
  localparam logic [PIX_W-1:0] PIX_ZERO_C    = PIX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [31:0]       block_r;
  logic [31:0]       block_nxt_s;
  logic [PIX_W-1:0]  pix_cnt_r;
  logic [PIX_W-1:0]  pix_nxt_s;
  logic [BC_W-1:0]   byte_cnt_r;
  logic [BC_W-1:0]   byte_nxt_s;

  logic              start_ok_s;
  logic              pix_take_s;
  logic              wr_s;
  logic              blk_done_s;
  logic              short_s;
  logic              frame_full_s;

  logic              req_nxt_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              err_nxt_s;

  // Per-cycle datapath decisions: byte/pixel accounting and block index update.
  always_comb begin
    start_ok_s   = 1'b0;
    pix_take_s   = 1'b0;
    wr_s         = 1'b0;
    blk_done_s   = 1'b0;
    byte_nxt_s   = byte_cnt_r;
    pix_nxt_s    = pix_cnt_r;
    short_s      = 1'b0;
    frame_full_s = 1'b0;
    block_nxt_s  = block_r;

    start_ok_s = (state_r == ST_IDLE) && start;
    pix_take_s = (state_r == ST_STREAM) && pixel_valid;
    blk_done_s = (state_r == ST_STREAM) && sd_rd_done;

    // Only bytes inside the block and inside the frame become writes;
    // anything past either bound (tail padding) is dropped.
    wr_s = pix_take_s && (pix_cnt_r < FRAME_PIX_C) && (byte_cnt_r < BLOCK_BYTES_C);

    // Byte counter saturates at the block size.
    if (pix_take_s && (byte_cnt_r < BLOCK_BYTES_C)) begin
      byte_nxt_s = byte_cnt_r + BC_ONE_C;
    end else begin
      byte_nxt_s = byte_cnt_r;
    end

    if (wr_s) begin
      pix_nxt_s = pix_cnt_r + PIX_ONE_C;
    end else begin
      pix_nxt_s = pix_cnt_r;
    end

    // A byte arriving together with sd_rd_done is already folded into
    // byte_nxt_s / pix_nxt_s, so the end-of-block decision sees it.
    short_s      = blk_done_s && (byte_nxt_s < BLOCK_BYTES_C);
    frame_full_s = (pix_nxt_s >= FRAME_PIX_C);

    if (start_ok_s) begin
      block_nxt_s = start_block;
    end else if (blk_done_s && !short_s && !frame_full_s) begin
      block_nxt_s = block_r + 32'd1;
    end else begin
      block_nxt_s = block_r;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic of the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (sd_rd_ack) begin
          state_nxt_s = ST_STREAM;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_STREAM: begin
        if (!sd_rd_done) begin
          state_nxt_s = ST_STREAM;
        end else if (short_s) begin
          state_nxt_s = ST_IDLE;
        end else if (frame_full_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so registered outputs line up with it.
  always_comb begin
    req_nxt_s  = 1'b0;
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    err_nxt_s  = error;

    req_nxt_s  = (state_nxt_s == ST_REQ);
    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);

    // Error is sticky until the next accepted start.
    if (start_ok_s) begin
      err_nxt_s = 1'b0;
    end else if (short_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = error;
    end
  end

  // Block index, pixel counter and in-block byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      block_r    <= 32'd0;
      pix_cnt_r  <= PIX_ZERO_C;
      byte_cnt_r <= BC_ZERO_C;
    end else begin
      block_r <= block_nxt_s;
      if (start_ok_s) begin
        pix_cnt_r  <= PIX_ZERO_C;
        byte_cnt_r <= BC_ZERO_C;
      end else if ((state_r == ST_REQ) && sd_rd_ack) begin
        byte_cnt_r <= BC_ZERO_C;
      end else begin
        pix_cnt_r  <= pix_nxt_s;
        byte_cnt_r <= byte_nxt_s;
      end
    end
  end

  // Registered outputs; the write address and data hold between writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sd_rd_req   <= 1'b0;
      sd_rd_block <= 32'd0;
      fb_we       <= 1'b0;
      fb_addr     <= '0;
      fb_wdata    <= 8'd0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      sd_rd_req   <= req_nxt_s;
      sd_rd_block <= block_nxt_s;
      fb_we       <= wr_s;
      if (wr_s) begin
        fb_addr  <= pix_cnt_r[ADDR_W-1:0];
        fb_wdata <= pixel_data;
      end
      busy       <= busy_nxt_s;
      frame_done <= done_nxt_s;
      error      <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_image_load_controller.sv
// Self-checking bench for image_load_controller. A small instance
// (4x3 frame, 8-byte blocks) covers the directed scenarios. A default-size
// instance covers a full 19200-pixel load.

module tb_image_load_controller;

  localparam int S_BB = 8;
  localparam int S_FP = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // small instance signals
  logic        s_start = 1'b0;
  logic [31:0] s_start_block = 32'd0;
  logic        s_sd_rd_req;
  logic [31:0] s_sd_rd_block;
  logic        s_sd_rd_ack = 1'b0;
  logic        s_sd_rd_done = 1'b0;
  logic [7:0]  s_pixel_data = 8'd0;
  logic        s_pixel_valid = 1'b0;
  logic        s_fb_we;
  logic [3:0]  s_fb_addr;
  logic [7:0]  s_fb_wdata;
  logic        s_busy, s_frame_done, s_error;

  // default-size instance signals
  logic        b_start = 1'b0;
  logic [31:0] b_start_block = 32'd0;
  logic        b_sd_rd_req;
  logic [31:0] b_sd_rd_block;
  logic        b_sd_rd_ack = 1'b0;
  logic        b_sd_rd_done = 1'b0;
  logic [7:0]  b_pixel_data = 8'd0;
  logic        b_pixel_valid = 1'b0;
  logic        b_fb_we;
  logic [14:0] b_fb_addr;
  logic [7:0]  b_fb_wdata;
  logic        b_busy, b_frame_done, b_error;

  image_load_controller #(.H_RES(4), .V_RES(3), .ADDR_W(4), .BLOCK_BYTES(8)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .start_block(s_start_block),
    .sd_rd_req(s_sd_rd_req), .sd_rd_block(s_sd_rd_block), .sd_rd_ack(s_sd_rd_ack),
    .sd_rd_done(s_sd_rd_done), .pixel_data(s_pixel_data), .pixel_valid(s_pixel_valid),
    .fb_we(s_fb_we), .fb_addr(s_fb_addr), .fb_wdata(s_fb_wdata), .busy(s_busy),
    .frame_done(s_frame_done), .error(s_error)
  );

  image_load_controller #(.H_RES(160), .V_RES(120), .ADDR_W(15), .BLOCK_BYTES(512)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .start_block(b_start_block),
    .sd_rd_req(b_sd_rd_req), .sd_rd_block(b_sd_rd_block), .sd_rd_ack(b_sd_rd_ack),
    .sd_rd_done(b_sd_rd_done), .pixel_data(b_pixel_data), .pixel_valid(b_pixel_valid),
    .fb_we(b_fb_we), .fb_addr(b_fb_addr), .fb_wdata(b_fb_wdata), .busy(b_busy),
    .frame_done(b_frame_done), .error(b_error)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- small-instance model ----------------
  int s_exp_addr_q[$];
  int s_exp_data_q[$];
  int s_exp_blk_q[$];
  int s_model_pix = 0;
  int s_cur_blk = 0;
  int s_exp_err = 0;
  int s_exp_done = 0;
  int s_wr_cnt = 0;
  int s_done_cnt = 0;
  int s_last_addr = 0;
  int s_last_data = 0;
  logic s_prev_done = 1'b0;

  // ---------------- big-instance model ----------------
  int b_exp_blk = 0;
  int b_req_cnt = 0;
  int b_wr_cnt = 0;
  int b_done_cnt = 0;
  int b_last_addr = -1;

  // Compare process for the small instance.
  always @(negedge clk) begin : s_compare
    int a, d;
    if (!reset) begin
      if (s_fb_we) begin
        if (s_exp_addr_q.size() == 0) begin
          chk("s_unexpected_write", 1, 0);
        end else begin
          a = s_exp_addr_q.pop_front();
          d = s_exp_data_q.pop_front();
          chk("s_wr_addr", s_fb_addr, a);
          chk("s_wr_data", s_fb_wdata, d);
          s_last_addr = a;
          s_last_data = d;
        end
        s_wr_cnt++;
      end else begin
        chk("s_addr_hold", s_fb_addr, s_last_addr);
        chk("s_data_hold", s_fb_wdata, s_last_data);
      end
      if (s_sd_rd_req && s_sd_rd_ack) begin
        if (s_exp_blk_q.size() == 0) chk("s_unexpected_req", 1, 0);
        else chk("s_req_block", s_sd_rd_block, s_exp_blk_q.pop_front());
      end
      if (s_frame_done) begin
        s_done_cnt++;
        chk("s_done_single_cycle", s_prev_done, 0);
      end
      s_prev_done = s_frame_done;
    end else begin
      s_prev_done = 1'b0;
    end
  end

  // Compare process for the default-size instance: pixel k lands at
  // address k and carries stream byte k (low 8 bits).
  always @(negedge clk) begin : b_compare
    if (!reset) begin
      if (b_fb_we) begin
        chk("b_wr_addr", b_fb_addr, b_wr_cnt);
        chk("b_wr_data", b_fb_wdata, b_wr_cnt % 256);
        b_last_addr = b_wr_cnt;
        b_wr_cnt++;
      end
      if (b_sd_rd_req && b_sd_rd_ack) begin
        chk("b_req_block", b_sd_rd_block, b_exp_blk);
        b_exp_blk++;
        b_req_cnt++;
      end
      if (b_frame_done) b_done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_start_load(input int blk);
    s_start = 1'b1;
    s_start_block = blk;
    s_model_pix = 0;
    s_cur_blk = blk;
    s_exp_blk_q.push_back(blk);
    s_exp_err = 0;
    step();
    s_start = 1'b0;
    s_start_block = 32'd0;
  endtask

  // Wait for a request, optionally stall the ack, then ack for one cycle.
  task automatic s_ack(input int stall);
    int n;
    n = 0;
    while (!s_sd_rd_req && n < 64) begin
      step();
      n++;
    end
    if (!s_sd_rd_req) begin
      chk("s_req_timeout", 0, 1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      step();
      chk("s_stall_req", s_sd_rd_req, 1);
      if (s_exp_blk_q.size() > 0) chk("s_stall_block", s_sd_rd_block, s_exp_blk_q[0]);
      chk("s_stall_no_we", s_fb_we, 0);
    end
    s_sd_rd_ack = 1'b1;
    step();
    s_sd_rd_ack = 1'b0;
  endtask

  // done_mode: 0 = done after the bytes, 1 = done with the last byte, 2 = no done
  task automatic s_deliver(input int n, input int base, input int done_mode);
    for (int i = 0; i < n; i++) begin
      s_pixel_valid = 1'b1;
      s_pixel_data = 8'(base + i);
      s_sd_rd_done = (done_mode == 1) && (i == n - 1);
      if (i < S_BB && s_model_pix < S_FP) begin
        s_exp_addr_q.push_back(s_model_pix);
        s_exp_data_q.push_back((base + i) % 256);
        s_model_pix++;
      end
      step();
    end
    s_pixel_valid = 1'b0;
    s_sd_rd_done = 1'b0;
    if (done_mode == 0) begin
      s_sd_rd_done = 1'b1;
      step();
      s_sd_rd_done = 1'b0;
    end
    if (done_mode != 2) begin
      if (n < S_BB) s_exp_err = 1;
      else if (s_model_pix >= S_FP) s_exp_done++;
      else begin
        s_cur_blk++;
        s_exp_blk_q.push_back(s_cur_blk);
      end
    end
  endtask

  task automatic b_ack();
    int n;
    n = 0;
    while (!b_sd_rd_req && n < 64) begin
      step();
      n++;
    end
    if (!b_sd_rd_req) begin
      chk("b_req_timeout", 0, 1);
      return;
    end
    b_sd_rd_ack = 1'b1;
    step();
    b_sd_rd_ack = 1'b0;
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int w0, d0, w37;
    // ---------- reset values ----------
    repeat (3) step();
    chk("rst_req", s_sd_rd_req, 0);
    chk("rst_block", s_sd_rd_block, 0);
    chk("rst_we", s_fb_we, 0);
    chk("rst_addr", s_fb_addr, 0);
    chk("rst_wdata", s_fb_wdata, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_frame_done, 0);
    chk("rst_error", s_error, 0);
    reset = 1'b0;
    step();

    // ---------- full small load, with a start while busy ----------
    w0 = s_wr_cnt;
    d0 = s_done_cnt;
    s_start_load(100);
    chk("t1_busy_n1", s_busy, 1);
    chk("t1_req_n1", s_sd_rd_req, 1);
    chk("t1_block_n1", s_sd_rd_block, 100);
    s_ack(0);
    chk("t1_req_drop", s_sd_rd_req, 0);
    s_start = 1'b1;
    s_start_block = 32'd7;
    step();
    s_start = 1'b0;
    s_start_block = 32'd0;
    chk("t1_start_ignored_busy", s_busy, 1);
    chk("t1_start_ignored_req", s_sd_rd_req, 0);
    s_deliver(8, 0, 0);
    chk("t1_next_req", s_sd_rd_req, 1);
    chk("t1_next_block", s_sd_rd_block, 101);
    s_ack(0);
    s_deliver(8, 8, 1);
    chk("t1_frame_done_edge", s_frame_done, 1);
    step();
    chk("t1_frame_done_off", s_frame_done, 0);
    chk("t1_busy_off", s_busy, 0);
    step();
    chk("t1_writes", s_wr_cnt - w0, 12);
    chk("t1_done_cnt", s_done_cnt - d0, 1);
    chk("t1_done_model", s_exp_done, 1);
    chk("t1_error", s_error, 0);
    chk("t1_last_addr", s_fb_addr, 11);
    chk("t1_last_data", s_fb_wdata, 8'h0B);
    chk("t1_wr_q_empty", s_exp_addr_q.size(), 0);
    chk("t1_blk_q_empty", s_exp_blk_q.size(), 0);

    // ---------- short block ----------
    w0 = s_wr_cnt;
    d0 = s_done_cnt;
    s_start_load(100);
    s_ack(0);
    s_deliver(5, 32'h20, 0);
    chk("t2_error_set", s_error, 1);
    chk("t2_busy_off", s_busy, 0);
    repeat (3) step();
    chk("t2_no_req", s_sd_rd_req, 0);
    chk("t2_writes", s_wr_cnt - w0, 5);
    chk("t2_no_done", s_done_cnt - d0, 0);
    chk("t2_err_model", s_error, s_exp_err);
    chk("t2_blk_q_empty", s_exp_blk_q.size(), 0);
    s_start_load(200);
    chk("t2_error_cleared", s_error, 0);
    chk("t2_busy_restart", s_busy, 1);

    // ---------- stalled ack, then reset mid-load ----------
    s_ack(20);
    w0 = s_wr_cnt;
    s_deliver(6, 32'h40, 2);
    step();
    chk("t3_writes_before_reset", s_wr_cnt - w0, 6);
    chk("t3_addr_before_reset", s_fb_addr, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("t3_rst_req", s_sd_rd_req, 0);
    chk("t3_rst_block", s_sd_rd_block, 0);
    chk("t3_rst_we", s_fb_we, 0);
    chk("t3_rst_addr", s_fb_addr, 0);
    chk("t3_rst_wdata", s_fb_wdata, 0);
    chk("t3_rst_busy", s_busy, 0);
    chk("t3_rst_error", s_error, 0);
    s_exp_addr_q.delete();
    s_exp_data_q.delete();
    s_exp_blk_q.delete();
    s_last_addr = 0;
    s_last_data = 0;
    step();
    reset = 1'b0;
    step();
    w0 = s_wr_cnt;
    d0 = s_done_cnt;
    s_start_load(100);
    s_ack(0);
    s_deliver(8, 32'h80, 1);
    s_ack(0);
    s_deliver(8, 32'h88, 0);
    repeat (2) step();
    chk("t3_restart_writes", s_wr_cnt - w0, 12);
    chk("t3_restart_done", s_done_cnt - d0, 1);
    chk("t3_restart_last_addr", s_fb_addr, 11);
    chk("t3_restart_last_data", s_fb_wdata, 8'h8B);

    // ---------- default parameters, full frame ----------
    w37 = 0;
    b_start = 1'b1;
    b_start_block = 32'd0;
    step();
    b_start = 1'b0;
    for (int k = 0; k < 38; k++) begin
      b_ack();
      if (k == 37) w37 = b_wr_cnt;
      for (int i = 0; i < 512; i++) begin
        b_pixel_valid = 1'b1;
        b_pixel_data = 8'(k * 512 + i);
        b_sd_rd_done = (i == 511);
        step();
      end
      b_pixel_valid = 1'b0;
      b_sd_rd_done = 1'b0;
    end
    repeat (3) step();
    chk("b_requests", b_req_cnt, 38);
    chk("b_writes", b_wr_cnt, 19200);
    chk("b_last_addr", b_last_addr, 19199);
    chk("b_fb_addr_hold", b_fb_addr, 19199);
    chk("b_final_block_writes", b_wr_cnt - w37, 256);
    chk("b_frame_done", b_done_cnt, 1);
    chk("b_error", b_error, 0);
    chk("b_busy", b_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/image_load_controller.md
# image_load_controller

Sequencer that loads one full RGB332 frame from the SD card into the framebuffer. It issues consecutive block reads to the SD read engine and counts the formatted pixel stream, one byte per pixel. It generates linear framebuffer write addresses and reports completion or protocol error. It sits between the SD read engine / image formatter output and the framebuffer write port.

## Interface
Parameters:
- H_RES, 160, pixels per line
- V_RES, 120, lines per frame
- ADDR_W, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- BLOCK_BYTES, 512, bytes delivered per SD block read

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begins a frame load; ignored while busy=1
- start_block  in  32  first SD block index, sampled on accepted start
- sd_rd_req  out  1  block read request, held until sd_rd_ack
- sd_rd_block  out  32  block index for current request
- sd_rd_ack  in  1  SD engine accepted request (same-cycle handshake with sd_rd_req)
- sd_rd_done  in  1  one-cycle pulse, current block fully delivered
- pixel_data  in  8  formatted pixel byte (RGB332)
- pixel_valid  in  1  pixel_data valid this cycle
- fb_we  out  1  framebuffer write strobe
- fb_addr  out  ADDR_W  framebuffer write address
- fb_wdata  out  8  framebuffer write data
- busy  out  1  high from accepted start until return to IDLE
- frame_done  out  1  one-cycle pulse on successful frame load
- error  out  1  sticky; set on short block; cleared by next accepted start

## Operation
- FRAME_PIX = H_RES*V_RES; NUM_BLOCKS = ceil(FRAME_PIX/BLOCK_BYTES).
- States: IDLE, REQ, STREAM, DONE.
- IDLE:
  - start=1: latch start_block into the block register, clear pix_cnt and byte_cnt, clear error, go to REQ.
- REQ:
  - sd_rd_req=1, sd_rd_block = current block.
  - sd_rd_ack=1: clear byte_cnt, go to STREAM.
- STREAM, on pixel_valid=1:
  - byte_cnt increments, saturating at BLOCK_BYTES.
  - If pix_cnt < FRAME_PIX and byte_cnt < BLOCK_BYTES: write byte at address pix_cnt, then increment pix_cnt.
  - Otherwise discard the byte; tail padding of the last block is dropped silently.
- STREAM, on sd_rd_done=1:
  - A pixel_valid in the same cycle is counted first.
  - Final byte count (including that byte) < BLOCK_BYTES: set error, go to IDLE. No frame_done.
  - Else pix_cnt (after that byte) >= FRAME_PIX: go to DONE.
  - Else increment block index (32-bit wrap), go to REQ.
- DONE: frame_done=1 for one cycle, go to IDLE.
- pixel_valid and sd_rd_done outside STREAM are ignored. start outside IDLE is ignored.
- busy = (state != IDLE).

## Timing
- Reset values: sd_rd_req=0, sd_rd_block=0, fb_we=0, fb_addr=0, fb_wdata=0, busy=0, frame_done=0, error=0, state=IDLE.
- Reset mid-load aborts immediately. No partial frame_done. Framebuffer contents already written are left as is.
- start in cycle N: busy=1 and sd_rd_req=1 from cycle N+1.
- sd_rd_req is registered. After ack in cycle N, it deasserts in N+1.
- Write latency is 1 cycle: pixel_valid in cycle N gives fb_we=1 in N+1 with that cycle's fb_addr/fb_wdata.
- fb_we is a single-cycle strobe per written pixel. Back-to-back pixel_valid gives back-to-back writes.
- fb_addr/fb_wdata hold their last value when fb_we=0.
- Final block: the last pixel write and the STREAM->DONE transition both occur on the completing sd_rd_done edge, so frame_done fires at earliest in the same cycle as the last fb_we.
- Next block request: sd_rd_done in cycle N gives sd_rd_req=1 in N+1 with incremented index.

## Test plan
- Params H_RES=4, V_RES=3, BLOCK_BYTES=8:
  - Stimulus: start with start_block=100; ack requests; deliver 8 bytes 0x00..0x07 then done; then 8 bytes 0x08..0x0F then done.
  - Required: requests for blocks 100 and 101; 12 writes, addr 0..11 with data 0x00..0x0B; bytes 0x0C..0x0F discarded; one frame_done pulse; error=0; busy low afterward.
- Short block:
  - Stimulus: same setup; block 100 delivers 5 bytes then sd_rd_done.
  - Required: 5 writes; error=1; no frame_done; state IDLE; no request for 101.
  - Follow-up: a new start clears error.
- Start while busy:
  - Stimulus: second start pulse during STREAM with start_block=7.
  - Required: ignored; block sequence unchanged.
- Stall tolerance:
  - Stimulus: hold sd_rd_ack low 20 cycles.
  - Required: sd_rd_req and sd_rd_block stable throughout; no fb_we.
- Reset mid-operation:
  - Stimulus: assert reset after 6 pixels.
  - Required: all outputs at reset values immediately.
  - Follow-up: a fresh start restarts at addr 0.
- Default params:
  - Stimulus: full load from start_block=0.
  - Required: 38 requests (blocks 0..37); 19200 writes; last fb_addr=19199; final block writes 256 bytes and discards 256; frame_done once.
